mul_hilo_ctl: RTL and testbench

Multi-cycle multiply sequencer owning the HI/LO register pair for the MIPS datapath. It accepts a `mul` issue from decode, runs an unsigned shift-add multiply one bit per cycle, and commits the 2·WIDTH-bit product to HI/LO. It serves `mfhi`/`mflo` reads selected by the ALU control `sel` code. It raises a pipeline stall while a dependent instruction must wait for the multiply to finish.

---
 rtl/mul_hilo_if.sv | 17 +
 rtl/mul_hilo_ctl.sv | 67 ++++++
 tb/tb_mul_hilo_ctl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mul_hilo_if.sv
// mul_hilo_if: decode-side bundle for the HI/LO multiply sequencer
//   master (decode): drives start, a, b, sel; sees busy, done, stall, hi, lo, hilo_out
//   slave  (mul_hilo_ctl): the reverse
interface mul_hilo_if #(parameter int WIDTH = 32);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       sel;
    logic             busy;
    logic             done;
    logic             stall;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hilo_out;
    modport master (output start, a, b, sel, input busy, done, stall, hi, lo, hilo_out);
    modport slave  (input start, a, b, sel, output busy, done, stall, hi, lo, hilo_out);
endinterface

// File: rtl/mul_hilo_ctl.sv
// mul_hilo_ctl: shift-add multiply sequencer owning HI/LO, with mfhi/mflo read and stall
//   clk, rst : clock, async active-high reset
//   bus      : mul_hilo_if.slave (start/a/b/sel in; busy/done/stall/hi/lo/hilo_out out)
module mul_hilo_ctl #(
    parameter int WIDTH = 32
) (
    input logic       clk,
    input logic       rst,
    mul_hilo_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t               r_state;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CW-1:0]        r_cnt;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_next;
    logic                 w_last;
    logic                 w_rd;
    // the add carry is shifted straight into the upper half, so no carry bit needs to persist
    assign w_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
    assign w_next = {w_sum, r_acc[WIDTH-1:1]};
    assign w_last = r_cnt == CW'(WIDTH - 1);
    assign w_rd   = bus.sel == 2'b01 || bus.sel == 2'b10;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_mcand <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        r_mcand <= bus.a;
                        r_acc   <= {{WIDTH{1'b0}}, bus.b};
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_acc <= w_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_hi    <= w_next[2*WIDTH-1:WIDTH];
                        r_lo    <= w_next[WIDTH-1:0];
                        r_state <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign bus.busy     = r_state == RUN;
    assign bus.done     = r_state == DONE;
    assign bus.stall    = bus.busy && (bus.start || w_rd);
    assign bus.hi       = r_hi;
    assign bus.lo       = r_lo;
    assign bus.hilo_out = bus.sel == 2'b01 ? r_hi : bus.sel == 2'b10 ? r_lo : '0;
endmodule

// File: tb/tb_mul_hilo_ctl.sv
// tb_mul_hilo_ctl: directed self-checking bench for mul_hilo_ctl (WIDTH=32)
module tb_mul_hilo_ctl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    mul_hilo_if #(.WIDTH(32)) bus ();
    mul_hilo_ctl #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // count cycles with busy high, bounded
    task automatic wait_busy(output int n);
        n = 0;
        while (bus.busy && n < 100) begin
            n++;
            cyc();
        end
    endtask

    task automatic run_mul(input string nm, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ehi, input logic [31:0] elo);
        int n;
        bus.start = 1'b1; bus.a = a; bus.b = b;
        cyc();
        bus.start = 1'b0;
        wait_busy(n);
        n_cmp++; if (n !== 32) begin n_err++; $display("FAIL %s busy_cycles got %0d want 32", nm, n); end
        n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL %s done got %b want 1", nm, bus.done); end
        n_cmp++; if (bus.hi !== ehi) begin n_err++; $display("FAIL %s hi got %h want %h", nm, bus.hi, ehi); end
        n_cmp++; if (bus.lo !== elo) begin n_err++; $display("FAIL %s lo got %h want %h", nm, bus.lo, elo); end
        cyc();
        n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL %s done_pulse got %b want 0", nm, bus.done); end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.sel = 2'b01;
        #1;
        n_cmp++; if ({bus.busy, bus.done, bus.stall} !== 3'b000) begin n_err++; $display("FAIL reset flags got %b want 000", {bus.busy, bus.done, bus.stall}); end
        n_cmp++; if ({bus.hi, bus.lo, bus.hilo_out} !== 96'h0) begin n_err++; $display("FAIL reset regs got %h want 0", {bus.hi, bus.lo, bus.hilo_out}); end
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            n_cmp++; if ({bus.busy, bus.done, bus.stall} !== 3'b000 || bus.hilo_out !== 32'h0) begin
                n_err++; $display("FAIL idle%0d flags/out got %b/%h want 000/0", i, {bus.busy, bus.done, bus.stall}, bus.hilo_out);
            end
        end
        bus.sel = 2'b00;
    endtask

    task automatic test_basic();
        run_mul("mul3x5", 32'd3, 32'd5, 32'h0, 32'hF);
        bus.sel = 2'b10;
        #1;
        n_cmp++; if (bus.hilo_out !== 32'hF) begin n_err++; $display("FAIL mflo got %h want 0000000f", bus.hilo_out); end
        bus.sel = 2'b11;
        #1;
        n_cmp++; if (bus.hilo_out !== 32'h0) begin n_err++; $display("FAIL sel11 got %h want 0", bus.hilo_out); end
        bus.sel = 2'b00;
    endtask

    task automatic test_corners();
        run_mul("mul_ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_mul("mul_80x2", 32'h8000_0000, 32'd2, 32'h1, 32'h0);
    endtask

    task automatic test_stall();
        int n = 0;
        int bad = 0;
        bus.start = 1'b1; bus.a = 32'h1234_5678; bus.b = 32'h100;
        cyc();
        bus.start = 1'b0; bus.sel = 2'b01;
        #1;
        while (bus.stall && n < 100) begin
            n++;
            if (bus.hi !== 32'h1 || bus.lo !== 32'h0) bad++;
            cyc();
        end
        n_cmp++; if (n !== 32) begin n_err++; $display("FAIL stall_cycles got %0d want 32", n); end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL hilo_hold early changes got %0d want 0", bad); end
        n_cmp++; if (bus.done !== 1'b1 || bus.stall !== 1'b0) begin n_err++; $display("FAIL stall_done done/stall got %b%b want 10", bus.done, bus.stall); end
        n_cmp++; if (bus.hilo_out !== 32'h12) begin n_err++; $display("FAIL mfhi_done got %h want 00000012", bus.hilo_out); end
        n_cmp++; if (bus.lo !== 32'h3456_7800) begin n_err++; $display("FAIL stall_lo got %h want 34567800", bus.lo); end
        bus.sel = 2'b00;
        cyc();
    endtask

    task automatic test_back_to_back();
        int n;
        bus.start = 1'b1; bus.a = 32'd3; bus.b = 32'd5;
        cyc();
        bus.start = 1'b0;
        cyc(); cyc(); cyc();
        bus.start = 1'b1; bus.a = 32'd7; bus.b = 32'd9;
        #1;
        n_cmp++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL start_in_run stall got %b want 1", bus.stall); end
        cyc();
        bus.start = 1'b0;
        wait_busy(n);
        n_cmp++; if (bus.done !== 1'b1 || bus.lo !== 32'd15) begin n_err++; $display("FAIL no_queue done/lo got %b/%0d want 1/15", bus.done, bus.lo); end
        cyc();
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL no_queue busy got %b want 0", bus.busy); end
        bus.start = 1'b1; bus.a = 32'd3; bus.b = 32'd5;
        cyc();
        cyc(); cyc();
        bus.a = 32'd7; bus.b = 32'd9;
        #1;
        while (bus.busy && n < 200) begin n++; cyc(); end
        n_cmp++; if (bus.done !== 1'b1 || bus.lo !== 32'd15 || bus.stall !== 1'b0) begin n_err++; $display("FAIL hold_done done/lo/stall got %b/%0d/%b want 1/15/0", bus.done, bus.lo, bus.stall); end
        cyc();
        bus.start = 1'b0;
        n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL restart busy got %b want 1", bus.busy); end
        wait_busy(n);
        n_cmp++; if (n !== 32) begin n_err++; $display("FAIL restart_cycles got %0d want 32", n); end
        n_cmp++; if (bus.lo !== 32'd63 || bus.hi !== 32'd0) begin n_err++; $display("FAIL restart hi/lo got %h/%h want 0/3f", bus.hi, bus.lo); end
        cyc();
    endtask

    task automatic test_reset_mid();
        bus.start = 1'b1; bus.a = 32'd5; bus.b = 32'd5;
        cyc();
        bus.start = 1'b0;
        for (int i = 0; i < 9; i++) cyc();
        rst = 1'b1;
        #1;
        n_cmp++; if ({bus.busy, bus.done} !== 2'b00 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
            n_err++; $display("FAIL async_rst busy/done/hi/lo got %b/%h/%h want 00/0/0", {bus.busy, bus.done}, bus.hi, bus.lo);
        end
        #1 rst = 1'b0;
        cyc();
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL post_rst busy got %b want 0", bus.busy); end
        run_mul("mul6x7", 32'd6, 32'd7, 32'h0, 32'd42);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
